// File: rtl/aes_key_expand.sv
// Iterative AES key schedule: loads Nk words on start, then writes one word per clock until Nw words exist.
// Optional AES_KEXP_RESTART_EN: a start during expansion restarts from the new key instead of being ignored.
module aes_key_expand #(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6,
    parameter int Nw = 4 * (Nr + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [32*Nk-1:0]  key,
    output logic              busy,
    output logic              done,
    output logic              key_valid,
    output logic [31:0]       rkey [Nw]
);

    typedef enum logic {IDLE, EXPAND} state_t;

    localparam logic [0:255][7:0] SBOX = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    state_t      state_q, state_d;
    logic [31:0] rkey_q [Nw];
    logic [31:0] rkey_d [Nw];
    logic [5:0]  i_q, i_d;
    logic [2:0]  j_q, j_d;
    logic [7:0]  rcon_q, rcon_d;
    logic        done_q, done_d;
    logic        kv_q, kv_d;
    logic        load;
    logic [31:0] w_prev;
    logic [31:0] temp;

`ifdef AES_KEXP_RESTART_EN
    assign load = start;
`else
    assign load = start && (state_q == IDLE);
`endif

    always_comb begin
        state_d = state_q;
        rkey_d  = rkey_q;
        i_d     = i_q;
        j_d     = j_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        kv_d    = kv_q;
        w_prev  = rkey_q[i_q - 6'd1];
        temp    = w_prev;
        // j tracks i mod Nk so the schedule position needs no divider
        if (j_q == 3'd0) begin
            temp = subword({w_prev[7:0], w_prev[31:8]}) ^ {24'h0, rcon_q};
        end else if (Nk == 8 && j_q == 3'd4) begin
            temp = subword(w_prev);
        end
        if (load) begin
            for (int k = 0; k < Nk; k++) begin
                rkey_d[k] = key[32*k +: 32];
            end
            i_d     = 6'(Nk);
            j_d     = 3'd0;
            rcon_d  = 8'h01;
            kv_d    = 1'b0;
            state_d = EXPAND;
        end else if (state_q == EXPAND) begin
            rkey_d[i_q] = rkey_q[i_q - 6'(Nk)] ^ temp;
            i_d = i_q + 6'd1;
            j_d = (j_q == 3'(Nk - 1)) ? 3'd0 : j_q + 3'd1;
            if (j_q == 3'd0) begin
                rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
            end
            if (i_q == 6'(Nw - 1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
                kv_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rkey_q  <= '{default: 32'h0};
            i_q     <= 6'(Nk);
            j_q     <= 3'd0;
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
            kv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rkey_q  <= rkey_d;
            i_q     <= i_d;
            j_q     <= j_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
            kv_q    <= kv_d;
        end
    end

    assign busy      = (state_q == EXPAND);
    assign done      = done_q;
    assign key_valid = kv_q;
    assign rkey      = rkey_q;

endmodule
